// File: rtl/ay_bus_pkg.sv
// ay_bus_pkg: shared state encoding, {bdir,bc1} bus modes and register count for the AY bus sequencer
package ay_bus_pkg;
  typedef enum logic [2:0] {RST_PULSE, IDLE, LATCH, LGAP, WRITE, READ, TGAP} ay_state_e;
  localparam logic [1:0] AY_INACTIVE = 2'b00;
  localparam logic [1:0] AY_READ     = 2'b01;
  localparam logic [1:0] AY_WRITE    = 2'b10;
  localparam logic [1:0] AY_LATCH    = 2'b11;
  localparam int AY_REG_COUNT = 16;
  function automatic logic [1:0] ay_mode(input ay_state_e s);
    return s == LATCH ? AY_LATCH : s == WRITE ? AY_WRITE : s == READ ? AY_READ : AY_INACTIVE;
  endfunction
endpackage

// File: rtl/ay_phase_timer.sv
// ay_phase_timer: loadable down-counter with ce-gated decrement; done flags the ce that finishes the phase
module ay_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk_logic,
  input  logic         ce_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_logic)
    cnt <= load ? load_val : (ce_i && cnt != '0) ? cnt - 1'b1 : cnt;
  assign done = ce_i && cnt <= W'(1);
endmodule

// File: rtl/ay_bus_sequencer.sv
// ay_bus_sequencer: AY-3-8913/YM2149 BDIR/BC1/DA bus initiator; define AY_READBACK_EN for the real read path
module ay_bus_sequencer
  import ay_bus_pkg::*;
#(
  parameter int HOLD_TICKS  = 1,
  parameter int GAP_TICKS   = 1,
  parameter int RESET_TICKS = 8
) (
  input  logic                            clk_logic,
  input  logic                            reset,
  input  logic                            ce_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_rd_i,
  input  logic [$clog2(AY_REG_COUNT)-1:0] req_addr_i,
  input  logic [7:0]                      req_data_i,
  output logic                            rsp_valid_o,
  output logic [7:0]                      rsp_data_o,
  input  logic                            chip_reset_i,
  output logic                            busy_o,
  output logic                            psg_bdir_o,
  output logic                            psg_bc1_o,
  output logic                            psg_reset_n_o,
  output logic [7:0]                      psg_da_o,
  output logic                            psg_da_oe_o,
  input  logic [7:0]                      psg_da_i
);
  localparam int MAX_T = HOLD_TICKS > GAP_TICKS ? (HOLD_TICKS > RESET_TICKS ? HOLD_TICKS : RESET_TICKS)
                                                : (GAP_TICKS > RESET_TICKS ? GAP_TICKS : RESET_TICKS);
  localparam int CW = $clog2(MAX_T + 1);
  ay_state_e state, state_n, data_st;
  logic pend, rd_q, done, accept, rsp_done;
  logic [7:0] data_q;
  logic [CW-1:0] len_n;
  assign busy_o      = state != IDLE;
  assign req_ready_o = state == IDLE && !pend && !chip_reset_i;
  assign accept      = req_valid_i && req_ready_o;
`ifdef AY_READBACK_EN
  assign data_st = rd_q ? READ : WRITE;
`else
  logic unused_da;
  assign unused_da = ^psg_da_i;
  assign data_st = rd_q ? IDLE : WRITE;
`endif
  always_comb begin
    state_n = state;
    case (state)
      RST_PULSE:   if (done) state_n = IDLE;
      IDLE:        state_n = (chip_reset_i || pend) ? RST_PULSE : req_valid_i ? LATCH : IDLE;
      LATCH:       if (done) state_n = GAP_TICKS == 0 ? data_st : LGAP;
      LGAP:        if (done) state_n = data_st;
      WRITE, READ: if (done) state_n = GAP_TICKS == 0 ? IDLE : TGAP;
      TGAP:        if (done) state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end
  assign len_n = reset                             ? CW'(RESET_TICKS)
               : state_n inside {LATCH, WRITE, READ} ? CW'(HOLD_TICKS)
               : state_n inside {LGAP, TGAP}         ? CW'(GAP_TICKS)
               : CW'(RESET_TICKS);
  assign rsp_done = rd_q && state != IDLE && state != RST_PULSE && state_n == IDLE;
  ay_phase_timer #(.W(CW)) u_timer (
    .clk_logic (clk_logic),
    .ce_i      (ce_i),
    .load      (reset || state_n != state),
    .load_val  (len_n),
    .done      (done)
  );
  // Bus pins are registered from the next state so they only move on state entry
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state         <= RST_PULSE;
      pend          <= 1'b0;
      rd_q          <= 1'b0;
      data_q        <= 8'h00;
      psg_bdir_o    <= 1'b0;
      psg_bc1_o     <= 1'b0;
      psg_reset_n_o <= 1'b0;
      psg_da_o      <= 8'h00;
      psg_da_oe_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= 8'h00;
    end else begin
      state <= state_n;
      pend  <= state == IDLE ? 1'b0 : pend || chip_reset_i;
      if (accept) begin
        rd_q   <= req_rd_i;
        data_q <= req_data_i;
      end
      {psg_bdir_o, psg_bc1_o} <= ay_mode(state_n);
      psg_reset_n_o <= state_n != RST_PULSE;
      psg_da_oe_o   <= state_n inside {LATCH, LGAP, WRITE};
      psg_da_o      <= accept ? {4'h0, req_addr_i} : state_n == WRITE ? data_q : psg_da_o;
      rsp_valid_o   <= rsp_done;
`ifdef AY_READBACK_EN
      if (state == READ && done) rsp_data_o <= psg_da_i;
`else
      if (rsp_done) rsp_data_o <= 8'hFF;
`endif
    end
  end
endmodule
